// File: rtl/irq_prio_ctrl.sv
// -----------------------------------------------------------------------------
// irq_prio_ctrl
// Nine-source priority interrupt controller. Falling edges on the active-low
// request lines are captured into a pending register. A mask register filters
// them, and the highest-priority eligible source is presented to a single
// consumer over an irq/ack handshake. An in-service register allows
// higher-priority sources to nest on top of lower ones. eoi_i retires the
// highest in-service source.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous reset, active-high
//   req_n     [8:0] request lines, active-low, synchronous to clk
//   mask_wr   load mask register from mask_din
//   mask_din  [8:0] mask value, 1 = source disabled
//   ack_i     consumer accepts the presented vector (used only while irq_o=1)
//   eoi_i     end of interrupt, clears the highest set in-service bit
//   irq_o     interrupt request to the consumer
//   vec_o     [3:0] presented source + 1, or 0 when irq_o=0
//   pend_o    [8:0] pending register
//   isr_o     [8:0] in-service register
// -----------------------------------------------------------------------------
module irq_prio_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] req_n,
  input  logic       mask_wr,
  input  logic [8:0] mask_din,
  input  logic       ack_i,
  input  logic       eoi_i,
  output logic       irq_o,
  output logic [3:0] vec_o,
  output logic [8:0] pend_o,
  output logic [8:0] isr_o
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ASSERT = 1'b1
  } state_t;

  // Index of the highest set bit; bit 8 has the highest priority.
  // The result is meaningless when v is zero, so callers qualify it with |v.
  function automatic logic [3:0] top_idx(input logic [8:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 9; i++) begin
      r = v[i] ? 4'(i) : r;
    end
    return r;
  endfunction

  function automatic logic [8:0] onehot(input logic [3:0] idx);
    return 9'b0_0000_0001 << idx;
  endfunction

  state_t     state_q, state_d;
  logic [8:0] pend_q, pend_d;
  logic [8:0] isr_q, isr_d;
  logic [8:0] mask_q, mask_d;
  logic [8:0] req_dly_q, req_dly_d;
  logic       irq_q, irq_d;
  logic [3:0] vec_q, vec_d;

  logic [8:0] fall_s;
  logic [8:0] cand_s;
  logic [3:0] cand_top_s;
  logic [3:0] isr_top_s;
  logic       elig_s;
  logic [8:0] isr_eoi_s;
  logic [8:0] ack_bit_s;

  // Next-state logic covering edge capture, priority selection, handshake and eoi.
  always_comb begin
    fall_s     = req_dly_q & ~req_n;
    cand_s     = pend_q & ~mask_q;
    cand_top_s = top_idx(cand_s);
    isr_top_s  = top_idx(isr_q);
    // A candidate must be strictly above everything already in service.
    elig_s     = (|cand_s) && (!(|isr_q) || (cand_top_s > isr_top_s));
    // eoi acts on the old isr; a same-cycle ack then ORs its own bit on top.
    isr_eoi_s  = (eoi_i && (|isr_q)) ? (isr_q & ~onehot(isr_top_s)) : isr_q;
    ack_bit_s  = onehot(vec_q - 4'd1);

    req_dly_d  = req_n;
    mask_d     = mask_wr ? mask_din : mask_q;
    pend_d     = pend_q | fall_s;
    isr_d      = isr_eoi_s;
    state_d    = state_q;
    irq_d      = irq_q;
    vec_d      = vec_q;

    case (state_q)
      ST_IDLE: begin
        if (elig_s) begin
          state_d = ST_ASSERT;
          irq_d   = 1'b1;
          vec_d   = cand_top_s + 4'd1;
        end else begin
          irq_d   = 1'b0;
          vec_d   = 4'd0;
        end
      end
      ST_ASSERT: begin
        if (ack_i) begin
          // A new fall on the acked source re-arms it in the same cycle.
          pend_d  = (pend_q & ~ack_bit_s) | fall_s;
          isr_d   = isr_eoi_s | ack_bit_s;
          state_d = ST_IDLE;
          irq_d   = 1'b0;
          vec_d   = 4'd0;
        end else begin
          state_d = ST_ASSERT;
          irq_d   = irq_q;
          vec_d   = vec_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        irq_d   = 1'b0;
        vec_d   = 4'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pend_q    <= 9'h000;
      isr_q     <= 9'h000;
      mask_q    <= 9'h000;
      req_dly_q <= 9'h1FF;
      irq_q     <= 1'b0;
      vec_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      isr_q     <= isr_d;
      mask_q    <= mask_d;
      req_dly_q <= req_dly_d;
      irq_q     <= irq_d;
      vec_q     <= vec_d;
    end
  end

  assign irq_o  = irq_q;
  assign vec_o  = vec_q;
  assign pend_o = pend_q;
  assign isr_o  = isr_q;

endmodule

// File: tb/tb_irq_prio_ctrl.sv
module tb_irq_prio_ctrl;

  logic       clk;
  logic       rst;
  logic [8:0] req_n;
  logic       mask_wr;
  logic [8:0] mask_din;
  logic       ack_i;
  logic       eoi_i;
  logic       irq_o;
  logic [3:0] vec_o;
  logic [8:0] pend_o;
  logic [8:0] isr_o;

  int n_cmp;
  int n_err;
  logic [3:0] exp_q[$];

  irq_prio_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .req_n   (req_n),
    .mask_wr (mask_wr),
    .mask_din(mask_din),
    .ack_i   (ack_i),
    .eoi_i   (eoi_i),
    .irq_o   (irq_o),
    .vec_o   (vec_o),
    .pend_o  (pend_o),
    .isr_o   (isr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ack();
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
  endtask

  task automatic do_eoi();
    eoi_i = 1'b1;
    tick();
    eoi_i = 1'b0;
  endtask

  // Wait a bounded number of cycles for irq_o, then pop and compare the vector.
  task automatic wait_irq(input string tag);
    int n;
    n = 0;
    while (!irq_o && n < 20) begin
      tick();
      n++;
    end
    check_val({tag, "_irq"}, 32'(irq_o), 32'd1);
    if (exp_q.size() > 0) begin
      check_val({tag, "_vec"}, 32'(vec_o), 32'(exp_q.pop_front()));
    end else begin
      check_val({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
    end
  endtask

  initial begin
    int rises;
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b1;
    req_n    = 9'h1FF;
    mask_wr  = 1'b0;
    mask_din = 9'h000;
    ack_i    = 1'b0;
    eoi_i    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_val("rst_irq", 32'(irq_o), 32'd0);
    check_val("rst_vec", 32'(vec_o), 32'd0);
    check_val("rst_pend", 32'(pend_o), 32'h000);
    check_val("rst_isr", 32'(isr_o), 32'h000);

    // 1: single source, exact latency
    req_n[3] = 1'b0;
    exp_q.push_back(4'd4);
    tick();
    check_val("t1_pend", 32'(pend_o), 32'h008);
    check_val("t1_irq_early", 32'(irq_o), 32'd0);
    tick();
    check_val("t1_lat_irq", 32'(irq_o), 32'd1);
    wait_irq("t1");
    do_ack();
    check_val("t1_isr", 32'(isr_o), 32'h008);
    check_val("t1_pend_clr", 32'(pend_o), 32'h000);
    check_val("t1_irq_off", 32'(irq_o), 32'd0);
    check_val("t1_vec_off", 32'(vec_o), 32'd0);
    req_n[3] = 1'b1;
    do_eoi();
    check_val("t1_eoi_isr", 32'(isr_o), 32'h000);

    // 2: two simultaneous sources, nesting blocks lower priority
    req_n[2] = 1'b0;
    req_n[7] = 1'b0;
    exp_q.push_back(4'd8);
    wait_irq("t2a");
    do_ack();
    check_val("t2_isr", 32'(isr_o), 32'h080);
    check_val("t2_pend", 32'(pend_o), 32'h004);
    tick();
    tick();
    tick();
    check_val("t2_blocked", 32'(irq_o), 32'd0);
    exp_q.push_back(4'd3);
    do_eoi();
    check_val("t2_eoi_isr", 32'(isr_o), 32'h000);
    wait_irq("t2b");
    do_ack();
    check_val("t2_isr2", 32'(isr_o), 32'h004);
    do_eoi();
    req_n[2] = 1'b1;
    req_n[7] = 1'b1;
    tick();

    // 3: higher priority nests over src1
    req_n[1] = 1'b0;
    exp_q.push_back(4'd2);
    wait_irq("t3a");
    do_ack();
    check_val("t3_isr1", 32'(isr_o), 32'h002);
    req_n[6] = 1'b0;
    exp_q.push_back(4'd7);
    wait_irq("t3b");
    do_ack();
    check_val("t3_isr_nest", 32'(isr_o), 32'h042);
    do_eoi();
    check_val("t3_eoi1", 32'(isr_o), 32'h002);
    do_eoi();
    check_val("t3_eoi2", 32'(isr_o), 32'h000);
    do_eoi();
    check_val("t3_eoi_empty", 32'(isr_o), 32'h000);
    req_n[1] = 1'b1;
    req_n[6] = 1'b1;
    tick();

    // 4: masked source stays pending, unmask releases it
    mask_wr  = 1'b1;
    mask_din = 9'h020;
    tick();
    mask_wr  = 1'b0;
    req_n[5] = 1'b0;
    tick();
    tick();
    tick();
    check_val("t4_pend", 32'(pend_o), 32'h020);
    check_val("t4_masked", 32'(irq_o), 32'd0);
    exp_q.push_back(4'd6);
    mask_wr  = 1'b1;
    mask_din = 9'h000;
    tick();
    mask_wr  = 1'b0;
    wait_irq("t4");
    do_ack();
    do_eoi();
    req_n[5] = 1'b1;
    tick();

    // 5: held-low level fires once; re-fall coinciding with ack keeps pending
    req_n[0] = 1'b0;
    exp_q.push_back(4'd1);
    wait_irq("t5a");
    do_ack();
    do_eoi();
    rises = 0;
    for (int i = 0; i < 18; i++) begin
      tick();
      if (irq_o) rises++;
    end
    check_val("t5_level_once", 32'(rises), 32'd0);
    check_val("t5_level_pend", 32'(pend_o), 32'h000);
    req_n[0] = 1'b1;
    tick();
    req_n[0] = 1'b0;
    exp_q.push_back(4'd1);
    wait_irq("t5b");
    req_n[0] = 1'b1;
    tick();
    check_val("t5_hold_irq", 32'(irq_o), 32'd1);
    req_n[0] = 1'b0;
    do_ack();
    check_val("t5_set_wins_pend", 32'(pend_o), 32'h001);
    check_val("t5_set_wins_isr", 32'(isr_o), 32'h001);
    check_val("t5_eq_blocked", 32'(irq_o), 32'd0);
    exp_q.push_back(4'd1);
    do_eoi();
    wait_irq("t5c");
    do_ack();
    do_eoi();
    req_n[0] = 1'b1;
    tick();

    // 6: reset during ASSERT overrides a simultaneous ack
    req_n[4] = 1'b0;
    exp_q.push_back(4'd5);
    wait_irq("t6");
    rst      = 1'b1;
    ack_i    = 1'b1;
    req_n[4] = 1'b1;
    tick();
    rst   = 1'b0;
    ack_i = 1'b0;
    check_val("t6_irq", 32'(irq_o), 32'd0);
    check_val("t6_vec", 32'(vec_o), 32'd0);
    check_val("t6_pend", 32'(pend_o), 32'h000);
    check_val("t6_isr", 32'(isr_o), 32'h000);
    do_ack();
    check_val("t6_ack_isr", 32'(isr_o), 32'h000);
    check_val("t6_ack_irq", 32'(irq_o), 32'd0);

    check_val("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
